// File: rtl/dnn_result_reader.sv
// Host-side sequencer for the fix8 inference engine: reset, start, wait for done, then argmax scan.
// Optional watchdog in WAIT is built only when RESULT_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module dnn_result_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CLASSES    = 10,
  parameter int IDX_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  output logic                  o_eng_reset,
  output logic                  o_eng_start,
  input  logic                  i_eng_done,
  output logic [IDX_WIDTH-1:0]  o_eng_idx,
  input  logic [DATA_WIDTH-1:0] i_eng_data,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [IDX_WIDTH-1:0]  o_res_class,
  output logic [DATA_WIDTH-1:0] o_res_score,
  output logic                  o_res_err,
  output logic [2:0]            o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Request side: ready only in IDLE. Result side: valid holds, with stable data, until ready.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_SCAN   = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  localparam logic [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_done_q;
  logic                          r_eng_reset;
  logic                          r_eng_start;
  logic                          r_res_valid;
  logic [IDX_WIDTH-1:0]          r_idx;
  logic [IDX_WIDTH-1:0]          r_best_class;
  logic signed [DATA_WIDTH-1:0]  r_best_score;
  logic [IDX_WIDTH-1:0]          r_res_class;
  logic [DATA_WIDTH-1:0]         r_res_score;
  logic                          w_done_edge;
  logic                          w_last;
  logic                          w_better;
  logic                          w_timeout;

  assign w_done_edge = i_eng_done && !r_done_q;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_better    = $signed(i_eng_data) > r_best_score;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_req_valid) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_START;
      S_START:  w_next = S_WAIT;
      S_WAIT: begin
        if (w_done_edge)    w_next = S_SCAN;
        else if (w_timeout) w_next = S_RESULT;
      end
      S_SCAN:   if (w_last) w_next = S_RESULT;
      S_RESULT: if (i_res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Pulses and res_valid are registered from the next state so they align with the state itself.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_done_q     <= 1'b0;
      r_eng_reset  <= 1'b0;
      r_eng_start  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_idx        <= '0;
      r_best_class <= '0;
      r_best_score <= MIN_SCORE;
      r_res_class  <= '0;
      r_res_score  <= '0;
    end else begin
      r_done_q    <= i_eng_done;
      r_eng_reset <= (w_next == S_CLEAR);
      r_eng_start <= (w_next == S_START);
      r_res_valid <= (w_next == S_RESULT);
      if (r_state == S_WAIT && w_done_edge) begin
        r_idx        <= '0;
        r_best_class <= '0;
        r_best_score <= MIN_SCORE;
      end else if (r_state == S_WAIT && w_timeout) begin
        r_res_class <= '1;
        r_res_score <= '0;
      end else if (r_state == S_SCAN) begin
        if (w_better) begin
          r_best_score <= i_eng_data;
          r_best_class <= r_idx;
        end
        if (w_last) begin
          r_res_class <= w_better ? r_idx : r_best_class;
          r_res_score <= w_better ? i_eng_data : r_best_score;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

`ifdef RESULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_res_err;

  // Counter is zero on the first WAIT cycle, so WAIT lasts TIMEOUT_CYCLES cycles at most.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_tmo_cnt <= '0;
      r_res_err <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == S_WAIT) ? r_tmo_cnt + 1'b1 : '0;
      if (w_timeout && !w_done_edge)              r_res_err <= 1'b1;
      else if (r_state == S_RESULT && i_res_ready) r_res_err <= 1'b0;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign o_res_err = r_res_err;
`else
  assign w_timeout = 1'b0;
  assign o_res_err = 1'b0;
`endif

  assign o_req_ready = (r_state == S_IDLE);
  assign o_eng_reset = r_eng_reset;
  assign o_eng_start = r_eng_start;
  assign o_eng_idx   = r_idx;
  assign o_res_valid = r_res_valid;
  assign o_res_class = r_res_class;
  assign o_res_score = r_res_score;
  assign o_dbg_state = r_state;

endmodule

// File: doc/dnn_result_reader.md
Name: dnn_result_reader

Overview:
- Host-side controller for the fix8 inference engine's control and result-select interface.
- On a host request it resets the engine, pulses start, and waits for done.
- It then scans the ten class outputs through the index/data select port and returns the argmax class and its score on a valid/ready result channel.
- Sits between the system host logic and the engine top level; it drives the engine's out_idx and reads the engine's out.

Parameters:
- DATA_WIDTH, 8, width of the signed class score returned by the engine
- NUM_CLASSES, 10, number of class outputs scanned (indices 0..NUM_CLASSES-1)
- IDX_WIDTH, 4, width of the class index / select bus
- TIMEOUT_CYCLES, 65535, watchdog limit in WAIT (used only with the optional feature)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  host requests one inference
- req_ready  out  1  high only in IDLE
- eng_reset  out  1  engine reset pulse
- eng_start  out  1  engine start pulse
- eng_done  in  1  engine done level
- eng_idx  out  IDX_WIDTH  class select to engine (engine out_idx)
- eng_data  in  DATA_WIDTH  signed score from engine, combinational in eng_idx
- res_valid  out  1  result available
- res_ready  in  1  host accepts result
- res_class  out  IDX_WIDTH  argmax class index
- res_score  out  DATA_WIDTH  signed max score
- res_err  out  1  timeout flag; constant 0 without the optional feature

Behaviour:
- Reset (rst=0, async): state=IDLE, req_ready=1, eng_reset=0, eng_start=0, eng_idx=0, res_valid=0, res_class=0, res_score=0, res_err=0, done_q=0.
- States and transitions:
  - IDLE: req_ready=1. req_valid&&req_ready -> CLEAR.
  - CLEAR: eng_reset=1 for exactly 1 cycle -> START.
  - START: eng_start=1 for exactly 1 cycle -> WAIT.
  - WAIT: done_q is the registered eng_done. The rising edge (eng_done && !done_q) -> SCAN with idx=0, best_score=most-negative value (-2^(DATA_WIDTH-1)), best_class=0. A done level already high on entry is ignored; only a fresh rising edge counts.
  - SCAN: one class per cycle. eng_idx=idx and eng_data is sampled the same cycle.
    - If eng_data > best_score (signed, strict), update best_score and best_class=idx.
    - On idx==NUM_CLASSES-1, take the final compare into account and go to RESULT. Otherwise idx++.
    - SCAN lasts exactly NUM_CLASSES cycles.
  - RESULT: res_valid=1 with res_class/res_score stable. res_ready -> IDLE, with res_valid dropping the next cycle.
- Ties: the lowest index wins (strict greater-than compare).
- All-minimum scores (all -128): class 0, score -128.
- Latency:
  - From request accept to res_valid = 2 + (cycles until the done edge) + NUM_CLASSES + 1.
  - With done rising N cycles after the START cycle, res_valid rises N+NUM_CLASSES+3 cycles after accept.
- Request handshake: req_valid is ignored outside IDLE. There is no queueing, and a request held high during RESULT is accepted only after the return to IDLE.
- Result handshake: res_ready with res_valid=0 has no effect. res_valid, once high, never drops without res_ready.
- Output timing: eng_idx holds its last value outside SCAN. All outputs are registered except req_ready, which is decoded from state.
- Reset mid-operation: any state returns to IDLE asynchronously, a partial scan is discarded, and no result is emitted.

Optional Feature:
- Macro: RESULT_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on WAIT entry.
  - If TIMEOUT_CYCLES cycles elapse without a done edge, go to RESULT with res_class={IDX_WIDTH{1'b1}}, res_score=0, res_err=1.
  - res_err clears when that result is accepted.
- Undefined: no counter is built, res_err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Basic: scores {3,-5,90,12,0,7,-128,45,89,1}, done 20 cycles after start -> res_class=2, res_score=90, res_valid 33 cycles after accept.
- Ties/negatives:
  - all scores -7 -> class 0, score -7.
  - scores with 127 at idx 4 and idx 9 -> class 4, score 127.
- Handshake: hold res_ready=0 for 15 cycles -> res_valid/res_class/res_score stable. Assert req_valid during WAIT -> ignored, req_ready=0. Back-to-back requests -> second accepted only in IDLE after res_ready.
- Stale done: eng_done held high from the previous run, drops after eng_reset, rises 5 cycles later -> scan starts only on that rising edge. eng_reset and eng_start are each observed as single-cycle pulses in order.
- Reset mid-SCAN: drop rst at idx=5 -> all outputs at reset values immediately. After release plus a new request, a full correct result is produced.
- With RESULT_TIMEOUT_EN and TIMEOUT_CYCLES=100, done never asserted -> res_valid with res_class=15, res_err=1 after timeout. Without the macro -> no result, res_err=0.
